// File: rtl/g_reg_file_scb.sv
// Register file with per-register reservation counters for decode/execute hazard tracking.
// Optional same-cycle writeback bypass on the read side is enabled by defining REG_BYPASS_EN.
module g_reg_file_scb #(
    parameter int W_RD  = 4,
    parameter int W_OPR = 32,
    parameter int W_RSV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_RD-1:0]  r0_i,
    input  logic [W_RD-1:0]  r1_i,
    output logic [W_OPR-1:0] r_opr0_o,
    output logic [W_OPR-1:0] r_opr1_o,
    output logic             reserved_o,
    input  logic             w_reserve_i,
    input  logic [W_RD-1:0]  w_reserve_r_i,
    output logic             rsv_full_o,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] result_i,
    input  logic             flush_i
);

    localparam int N_REG = 2 ** W_RD;
    localparam logic [W_RSV-1:0] CNT_MAX  = {W_RSV{1'b1}};
    localparam logic [W_RSV-1:0] CNT_ZERO = '0;
    localparam logic [W_RSV-1:0] CNT_ONE  = W_RSV'(1);

    logic [W_OPR-1:0] regs    [N_REG];
    logic [W_RSV-1:0] cnt     [N_REG];
    logic [W_RSV-1:0] cnt_nxt [N_REG];

    logic [W_RSV-1:0] cnt_rd0;
    logic [W_RSV-1:0] cnt_rd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_REG; k++) begin
                regs[k] <= '0;
            end
        end else if (wb_i) begin
            regs[wb_r_i] <= result_i;
        end
    end

    // Reserve and writeback hitting the same register cancel; a flush drops every
    // reservation, but the writeback data path above is unaffected by it.
    always_comb begin
        for (int k = 0; k < N_REG; k++) begin
            cnt_nxt[k] = cnt[k];
            if (flush_i) begin
                cnt_nxt[k] = CNT_ZERO;
            end else if (w_reserve_i && (w_reserve_r_i == W_RD'(k)) &&
                         wb_i && (wb_r_i == W_RD'(k))) begin
                cnt_nxt[k] = cnt[k];
            end else if (w_reserve_i && (w_reserve_r_i == W_RD'(k))) begin
                if (cnt[k] != CNT_MAX) begin
                    cnt_nxt[k] = cnt[k] + CNT_ONE;
                end
            end else if (wb_i && (wb_r_i == W_RD'(k))) begin
                if (cnt[k] != CNT_ZERO) begin
                    cnt_nxt[k] = cnt[k] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_REG; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REG; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

`ifdef REG_BYPASS_EN
    // An in-flight writeback is forwarded and its reservation treated as already retired.
    always_comb begin
        r_opr0_o = regs[r0_i];
        r_opr1_o = regs[r1_i];
        cnt_rd0  = cnt[r0_i];
        cnt_rd1  = cnt[r1_i];
        if (wb_i && (wb_r_i == r0_i)) begin
            r_opr0_o = result_i;
            if (cnt[r0_i] != CNT_ZERO) begin
                cnt_rd0 = cnt[r0_i] - CNT_ONE;
            end
        end
        if (wb_i && (wb_r_i == r1_i)) begin
            r_opr1_o = result_i;
            if (cnt[r1_i] != CNT_ZERO) begin
                cnt_rd1 = cnt[r1_i] - CNT_ONE;
            end
        end
    end
`else
    always_comb begin
        r_opr0_o = regs[r0_i];
        r_opr1_o = regs[r1_i];
        cnt_rd0  = cnt[r0_i];
        cnt_rd1  = cnt[r1_i];
    end
`endif

    assign reserved_o = (cnt_rd0 != CNT_ZERO) | (cnt_rd1 != CNT_ZERO);
    assign rsv_full_o = (cnt[w_reserve_r_i] == CNT_MAX);

endmodule
